vga_pixel_driver: RTL



---
 rtl/vga_pixel_driver.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/vga_pixel_driver.sv
// -----------------------------------------------------------------------------
// vga_pixel_driver
//
// Raster timing generator and pixel output stage for the 640x480@60 VGA path.
// Owns the horizontal/vertical counters that every drawing object reads as
// pixelX/pixelY. Takes back the RGB332 pixel chosen by the objects mux and
// drives the DAC pins. Sync and blanking are aligned with that pixel through a
// matched delay line.
//
// Ports:
//   clk          in   25 MHz pixel clock
//   resetN       in   asynchronous, active-low reset
//   RGBIn[7:0]   in   RRRGGGBB pixel from the objects mux, PIPE_LAT clocks
//                     after the matching pixelX/pixelY
//   pixelX[10:0] out  horizontal count (hCnt); >= H_ACTIVE is blanking
//   pixelY[10:0] out  vertical count (vCnt);   >= V_ACTIVE is blanking
//   startOfFrame out  high while hCnt==0 && vCnt==0 (one clock per frame)
//   red/green/blue[3:0] out  expanded colour to the DAC, zero in blanking
//   hSync, vSync out  active-low syncs
//   blankN       out  high while the output pixel is visible
//
// Latency: counters at (x,y) on cycle t reach the pins on cycle t+PIPE_LAT+1,
// registered together with the RGBIn sampled on cycle t+PIPE_LAT.
//
// Build option: define VGA_TEST_PATTERN_EN to ignore RGBIn and output eight
// 64-pixel colour bars generated from hCnt[8:6]. The bar pixel rides the same
// delay line as sync/blank so its latency is identical.
// -----------------------------------------------------------------------------
module vga_pixel_driver #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int PIPE_LAT = 1
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [7:0]  RGBIn,
  output logic [10:0] pixelX,
  output logic [10:0] pixelY,
  output logic        startOfFrame,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        hSync,
  output logic        vSync,
  output logic        blankN
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS  = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  // Delay-line slot layout: [2]=active, [1]=hs, [0]=vs, and in the
  // test-pattern build the bar pixel sits above them in [10:3].
`ifdef VGA_TEST_PATTERN_EN
  localparam int PW = 11;
`else
  localparam int PW = 3;
`endif
  // Idle slot: not visible, both syncs deasserted (high), pixel zero.
  localparam logic [PW-1:0] SLOT_IDLE = PW'(3'b011);

  // ---------------------------------------------------------------------------
  // Raster counters
  // ---------------------------------------------------------------------------
  logic [10:0] r_h_cnt;
  logic [10:0] r_v_cnt;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (r_h_cnt == H_LAST) begin
      r_h_cnt <= '0;
      r_v_cnt <= (r_v_cnt == V_LAST) ? 11'd0 : r_v_cnt + 11'd1;
    end else begin
      r_h_cnt <= r_h_cnt + 11'd1;
    end
  end

  assign pixelX       = r_h_cnt;
  assign pixelY       = r_v_cnt;
  assign startOfFrame = (r_h_cnt == 11'd0) && (r_v_cnt == 11'd0);

  // ---------------------------------------------------------------------------
  // Stage 0: decode the counters
  // ---------------------------------------------------------------------------
  logic          w_active;
  logic          w_hs;
  logic          w_vs;
  logic [PW-1:0] w_stage0;

  assign w_active = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
  assign w_hs     = !((r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END));
  assign w_vs     = !((r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END));

`ifdef VGA_TEST_PATTERN_EN
  // Bar index repeats every 512 pixels; each bit of k is replicated into
  // one colour field so bar k=7 is full white and k=0 is black.
  logic [2:0] w_bar_k;
  logic [7:0] w_bar_pix;
  assign w_bar_k   = r_h_cnt[8:6];
  assign w_bar_pix = {{3{w_bar_k[2]}}, {3{w_bar_k[1]}}, {2{w_bar_k[0]}}};
  assign w_stage0  = {w_bar_pix, w_active, w_hs, w_vs};
`else
  assign w_stage0  = {w_active, w_hs, w_vs};
`endif

  // ---------------------------------------------------------------------------
  // Matched delay line: PIPE_LAT stages so the decode lines up with the
  // pixel the objects mux returns for the same coordinates.
  // ---------------------------------------------------------------------------
  logic [PW-1:0] w_dly;

  generate
    if (PIPE_LAT == 0) begin : g_no_dly
      assign w_dly = w_stage0;
    end else begin : g_dly
      logic [PW-1:0] r_pipe [PIPE_LAT];

      always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
          for (int i = 0; i < PIPE_LAT; i++) begin
            r_pipe[i] <= SLOT_IDLE;
          end
        end else begin
          r_pipe[0] <= w_stage0;
          for (int i = 1; i < PIPE_LAT; i++) begin
            r_pipe[i] <= r_pipe[i-1];
          end
        end
      end

      assign w_dly = r_pipe[PIPE_LAT-1];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Pixel source for the output register
  // ---------------------------------------------------------------------------
  logic [7:0] w_pix_out;

`ifdef VGA_TEST_PATTERN_EN
  logic w_unused_rgb;
  assign w_unused_rgb = ^RGBIn;
  assign w_pix_out    = w_dly[PW-1:3];
`else
  assign w_pix_out    = RGBIn;
`endif

  // ---------------------------------------------------------------------------
  // Output register: sync, blank and expanded colour change on the same edge.
  // The top bit of each 3-bit field is replicated into the LSB so full scale
  // reaches 0xF; blue's two bits are simply doubled.
  // ---------------------------------------------------------------------------
  logic [3:0] r_red;
  logic [3:0] r_green;
  logic [3:0] r_blue;
  logic       r_hs;
  logic       r_vs;
  logic       r_blank_n;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_red     <= '0;
      r_green   <= '0;
      r_blue    <= '0;
      r_hs      <= 1'b1;
      r_vs      <= 1'b1;
      r_blank_n <= 1'b0;
    end else begin
      r_hs      <= w_dly[1];
      r_vs      <= w_dly[0];
      r_blank_n <= w_dly[2];
      if (w_dly[2]) begin
        r_red   <= {w_pix_out[7:5], w_pix_out[7]};
        r_green <= {w_pix_out[4:2], w_pix_out[4]};
        r_blue  <= {w_pix_out[1:0], w_pix_out[1:0]};
      end else begin
        r_red   <= '0;
        r_green <= '0;
        r_blue  <= '0;
      end
    end
  end

  assign red    = r_red;
  assign green  = r_green;
  assign blue   = r_blue;
  assign hSync  = r_hs;
  assign vSync  = r_vs;
  assign blankN = r_blank_n;

endmodule
